// File: rtl/clock_top.sv
// clock_top: 24 h clock with alarm, stopwatch and a 4-digit multiplexed 7-segment display.
// Define KEY_DEBOUNCE_EN to require keys to be stable for 20 ms before an edge is accepted.

module clock_top #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       clock,
  input  logic       sel,
  input  logic       stop,
  input  logic       clr,
  output logic [3:0] an,
  output logic [7:0] out,
  output logic       beep
);

  // Display scan FSM
  // state   | meaning
  // SC_IDLE | out of reset, all digits blank
  // SC_D3   | leftmost digit (an[3]) driven
  // SC_D2   | digit an[2] driven, carries the decimal point
  // SC_D1   | digit an[1] driven
  // SC_D0   | rightmost digit (an[0]) driven

  typedef enum logic [2:0] {SC_IDLE, SC_D3, SC_D2, SC_D1, SC_D0} scan_t;

  localparam int DIV_S = (CLK_HZ > 1) ? CLK_HZ : 1;
  localparam int DIV_C = (CLK_HZ / 100 > 1) ? CLK_HZ / 100 : 1;
  localparam int N_SC  = (SCAN_DIV > 1) ? SCAN_DIV : 1;
  localparam int W_S   = (DIV_S > 1) ? $clog2(DIV_S) : 1;
  localparam int W_C   = (DIV_C > 1) ? $clog2(DIV_C) : 1;
  localparam int W_SC  = (N_SC > 1) ? $clog2(N_SC) : 1;
  localparam logic [W_S-1:0]  S_MAX  = W_S'(DIV_S - 1);
  localparam logic [W_S-1:0]  S_HALF = W_S'(DIV_S / 2);
  localparam logic [W_C-1:0]  C_MAX  = W_C'(DIV_C - 1);
  localparam logic [W_SC-1:0] SC_MAX = W_SC'(N_SC - 1);

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'd0;
    ones = v[3:0];
    for (int i = 1; i <= 9; i++) begin
      if (v >= 7'(i * 10)) begin
        tens = 4'(i);
        ones = 4'(v - 7'(i * 10));
      end
    end
    return {tens, ones};
  endfunction

  // {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [W_S-1:0]  div_s;
  logic [W_C-1:0]  div_c;
  logic            tick_s, tick_c;
  logic [3:0]      key_s1, key_s2, key_lvl, key_prev, pulse;
  logic [4:0]      tod_hour, alm_hour;
  logic [5:0]      tod_min, tod_sec, alm_min, sw_sec;
  logic [6:0]      sw_cs;
  logic            alarm_en, silence, match;
  logic            p_h, p_m, p_s, a_h, a_m, sec_wrap, min_wrap;
  logic [7:0]      bcd_hi, bcd_lo;
  logic            dp2;
  logic [7:0]      digit_seg [4];
  scan_t           scan_state;
  logic [W_SC-1:0] scan_cnt;

  // Up-counting dividers so a cleared divider yields its first tick a full period later
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      div_s <= '0;
      div_c <= '0;
    end else begin
      div_s <= (div_s == S_MAX) ? '0 : div_s + 1'b1;
      div_c <= (div_c == C_MAX) ? '0 : div_c + 1'b1;
    end
  end

  assign tick_s = (div_s == S_MAX);
  assign tick_c = (div_c == C_MAX);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DB_CYC = (CLK_HZ / 50 > 1) ? CLK_HZ / 50 : 1;
  localparam int W_DB   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [W_DB-1:0] DB_MAX = W_DB'(DB_CYC - 1);

  logic [W_DB-1:0] db_cnt [4];
  logic [3:0]      key_stable;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      key_stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= DB_MAX;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_s2[i] == key_stable[i]) begin
          db_cnt[i] <= DB_MAX;
        end else if (db_cnt[i] == '0) begin
          key_stable[i] <= key_s2[i];
          db_cnt[i]     <= DB_MAX;
        end else begin
          db_cnt[i] <= db_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign key_lvl = key_stable;
`else
  assign key_lvl = key_s2;
`endif

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) key_prev <= '0;
    else     key_prev <= key_lvl;
  end

  assign pulse = key_lvl & ~key_prev;
  assign p_h   = pulse[0] & ~clock;
  assign p_m   = pulse[1] & ~clock;
  assign p_s   = pulse[2] & ~clock;
  assign a_h   = pulse[0] & clock;
  assign a_m   = pulse[1] & clock;

  // A key edit of a field suppresses the carry out of that field
  assign sec_wrap = tick_s && (tod_sec == 6'd59) && !p_s;
  assign min_wrap = sec_wrap && (tod_min == 6'd59) && !p_m;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      tod_hour <= '0;
      tod_min  <= '0;
      tod_sec  <= '0;
    end else begin
      if (p_s)
        tod_sec <= '0;
      else if (tick_s)
        tod_sec <= (tod_sec == 6'd59) ? '0 : tod_sec + 1'b1;

      if (p_m || sec_wrap)
        tod_min <= (tod_min == 6'd59) ? '0 : tod_min + 1'b1;

      if (p_h || min_wrap)
        tod_hour <= (tod_hour == 5'd23) ? '0 : tod_hour + 1'b1;
    end
  end

  assign match = (tod_hour == alm_hour) && (tod_min == alm_min);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      alm_hour <= '0;
      alm_min  <= '0;
      alarm_en <= 1'b0;
      silence  <= 1'b0;
      beep     <= 1'b0;
    end else begin
      if (a_h) alm_hour <= (alm_hour == 5'd23) ? '0 : alm_hour + 1'b1;
      if (a_m) alm_min  <= (alm_min == 6'd59) ? '0 : alm_min + 1'b1;
      if (pulse[3]) alarm_en <= ~alarm_en;
      if (beep && (|pulse))
        silence <= 1'b1;
      else if (!match)
        silence <= 1'b0;
      beep <= alarm_en && match && !silence;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sw_cs  <= '0;
      sw_sec <= '0;
    end else if (clr) begin
      sw_cs  <= '0;
      sw_sec <= '0;
    end else if (!stop && tick_c) begin
      if (sw_cs == 7'd99) begin
        sw_cs  <= '0;
        sw_sec <= (sw_sec == 6'd59) ? '0 : sw_sec + 1'b1;
      end else begin
        sw_cs <= sw_cs + 1'b1;
      end
    end
  end

  always_comb begin
    bcd_hi = 8'h00;
    bcd_lo = 8'h00;
    dp2    = 1'b0;
    if (sel) begin
      bcd_hi = to_bcd({1'b0, sw_sec});
      bcd_lo = to_bcd(sw_cs);
      dp2    = 1'b1;
    end else if (clock) begin
      bcd_hi = to_bcd({2'b00, alm_hour});
      bcd_lo = to_bcd({1'b0, alm_min});
      dp2    = 1'b1;
    end else begin
      bcd_hi = to_bcd({2'b00, tod_hour});
      bcd_lo = to_bcd({1'b0, tod_min});
      dp2    = (div_s < S_HALF);
    end
    digit_seg[3] = {1'b1, seg7(bcd_hi[7:4])};
    digit_seg[2] = {~dp2, seg7(bcd_hi[3:0])};
    digit_seg[1] = {1'b1, seg7(bcd_lo[7:4])};
    digit_seg[0] = {1'b1, seg7(bcd_lo[3:0])};
  end

  // Segments are refreshed every cycle so a held digit tracks changing content
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      scan_state <= SC_IDLE;
      scan_cnt   <= '0;
      an         <= 4'b1111;
      out        <= 8'hFF;
    end else if (scan_cnt == '0) begin
      scan_cnt <= SC_MAX;
      case (scan_state)
        SC_D3: begin
          scan_state <= SC_D2;
          an         <= 4'b1011;
          out        <= digit_seg[2];
        end
        SC_D2: begin
          scan_state <= SC_D1;
          an         <= 4'b1101;
          out        <= digit_seg[1];
        end
        SC_D1: begin
          scan_state <= SC_D0;
          an         <= 4'b1110;
          out        <= digit_seg[0];
        end
        default: begin
          scan_state <= SC_D3;
          an         <= 4'b0111;
          out        <= digit_seg[3];
        end
      endcase
    end else begin
      scan_cnt <= scan_cnt - 1'b1;
      case (scan_state)
        SC_D3:   out <= digit_seg[3];
        SC_D2:   out <= digit_seg[2];
        SC_D1:   out <= digit_seg[1];
        SC_D0:   out <= digit_seg[0];
        default: out <= 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_top.sv
// tb_clock_top: scoreboard bench for clock_top with CLK_HZ=100, SCAN_DIV=2.
// Expected values are queued as stimulus is applied and popped at each observation.

module tb_clock_top;

  logic       mclk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'b0000;
  logic       clock = 1'b0;
  logic       sel = 1'b0;
  logic       stop = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] an;
  logic [7:0] out;
  logic       beep;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  clock_top #(.CLK_HZ(100), .SCAN_DIV(2)) dut (
    .mclk(mclk), .rst(rst), .key(key), .clock(clock), .sel(sel),
    .stop(stop), .clr(clr), .an(an), .out(out), .beep(beep)
  );

  always #5 mclk = ~mclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input int v);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input string tag, input int obs);
    int e;
    if (exp_q.size() == 0) e = -1;
    else e = exp_q.pop_front();
    chk(tag, obs, e);
  endtask

  task automatic press(input int k);
    @(negedge mclk);
    key[k] = 1'b1;
    repeat (4) @(negedge mclk);
    key[k] = 1'b0;
    repeat (4) @(negedge mclk);
  endtask

  task automatic press_n(input int k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  function automatic logic [3:0] an_exp(input int d);
    logic [3:0] m;
    m = 4'b1000 >> d;
    return ~m;
  endfunction

  // Align to the start of a scan round, then sample each digit once
  task automatic capture(input string tag, input bit ign_dp);
    logic [3:0] prev;
    logic [7:0] o;
    bit found;
    found = 1'b0;
    prev = an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge mclk);
      if (an == 4'b0111 && prev != 4'b0111) found = 1'b1;
      else prev = an;
    end
    chk({tag, "_sync"}, int'(found), 1);
    for (int d = 0; d < 4; d++) begin
      if (found) begin
        if (d > 0) repeat (2) @(negedge mclk);
        o = out;
        if (d == 1 && ign_dp) o[7] = 1'b1;
        chk({tag, "_an"}, int'(an), int'(an_exp(d)));
        check_next({tag, "_seg"}, int'(o));
      end else if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic wait_sec(input int v, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(dut.tod_sec) != v && n < budget) begin
      @(negedge mclk);
      n++;
    end
    chk(tag, int'(n < budget), 1);
  endtask

  task automatic wait_min(input int v, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(dut.tod_min) != v && n < budget) begin
      @(negedge mclk);
      n++;
    end
    chk(tag, int'(n < budget), 1);
  endtask

  initial begin
    int n;
    int lit;
    int dark;

    // reset state
    repeat (3) @(negedge mclk);
    expect_v(4'hF);  check_next("rst_an", an);
    expect_v(8'hFF); check_next("rst_out", out);
    expect_v(0);     check_next("rst_beep", beep);
    expect_v(0);     check_next("rst_sec", dut.tod_sec);
    @(negedge mclk);
    rst = 1'b0;
    repeat (99) @(posedge mclk);
    #1 expect_v(0); check_next("sec_99", dut.tod_sec);
    @(posedge mclk);
    #1 expect_v(1); check_next("sec_100", dut.tod_sec);

    // time setting keys
    clock = 1'b0;
    expect_v(3); press_n(0, 3); check_next("hour3", dut.tod_hour);
    press(2);
    expect_v(59); press_n(1, 59); check_next("min59", dut.tod_min);
    expect_v(0); expect_v(3);
    press(1);
    check_next("min_wrap", dut.tod_min);
    check_next("hour_keep", dut.tod_hour);

    // 23:59:59 -> 00:00:00
    press_n(0, 20);
    press_n(1, 59);
    press(2);
    wait_sec(59, 6200, "wait_59");
    expect_v(23); check_next("pre_hour", dut.tod_hour);
    expect_v(59); check_next("pre_min", dut.tod_min);
    n = 0;
    while (int'(dut.tod_sec) == 59 && n < 200) begin
      @(negedge mclk);
      n++;
    end
    expect_v(0); check_next("wrap_sec", dut.tod_sec);
    expect_v(0); check_next("wrap_min", dut.tod_min);
    expect_v(0); check_next("wrap_hour", dut.tod_hour);

    // scan of 12:34 in time view
    press_n(0, 12);
    press_n(1, 34);
    expect_v(8'hF9); expect_v(8'hA4); expect_v(8'hB0); expect_v(8'h99);
    capture("scan_time", 1'b1);
    lit = 0;
    dark = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge mclk);
      if (an == 4'b1011) begin
        if (out[7] == 1'b0) lit++;
        else dark++;
      end
    end
    chk("blink_on", int'(lit > 0), 1);
    chk("blink_off", int'(dark > 0), 1);

    // alarm set to 00:01 and enabled
    @(negedge mclk) clock = 1'b1;
    press(1);
    expect_v(8'hC0); expect_v(8'h40); expect_v(8'hC0); expect_v(8'hF9);
    capture("alarm_view", 1'b0);
    expect_v(1); press(3); check_next("alarm_en", dut.alarm_en);
    @(negedge mclk) clock = 1'b0;
    press_n(0, 12);
    press_n(1, 26);
    expect_v(0); check_next("set_hour0", dut.tod_hour);
    expect_v(0); check_next("set_min0", dut.tod_min);
    press(2);
    expect_v(0); check_next("beep_early", beep);
    wait_min(1, 6200, "wait_0001");
    repeat (3) @(negedge mclk);
    expect_v(1); check_next("beep_on", beep);
    press(1);
    expect_v(0); check_next("beep_key", beep);
    expect_v(2); check_next("min_0002", dut.tod_min);
    expect_v(0); check_next("sil_clr", dut.silence);

    // silence with an unchanged match, released on the next minute
    @(negedge mclk) clock = 1'b1;
    expect_v(1); press(1); check_next("beep_0002", beep);
    press(2);
    expect_v(0); check_next("beep_sil", beep);
    expect_v(1); check_next("sil_set", dut.silence);
    @(negedge mclk) clock = 1'b0;
    wait_min(3, 6200, "wait_0003");
    repeat (2) @(negedge mclk);
    expect_v(0); check_next("sil_release", dut.silence);
    expect_v(0); check_next("beep_0003", beep);

    // stopwatch
    @(negedge mclk);
    sel = 1'b1;
    clr = 1'b1;
    repeat (3) @(negedge mclk);
    clr = 1'b0;
    repeat (150) @(negedge mclk);
    stop = 1'b1;
    repeat (5) @(negedge mclk);
    expect_v(8'hC0); expect_v(8'h79); expect_v(8'h92); expect_v(8'hC0);
    capture("sw_run", 1'b0);
    repeat (50) @(negedge mclk);
    expect_v(8'hC0); expect_v(8'h79); expect_v(8'h92); expect_v(8'hC0);
    capture("sw_frozen", 1'b0);
    clr = 1'b1;
    repeat (3) @(negedge mclk);
    expect_v(8'hC0); expect_v(8'h40); expect_v(8'hC0); expect_v(8'hC0);
    capture("sw_clr", 1'b0);
    sel = 1'b0;
    clr = 1'b0;
    stop = 1'b0;

    // reset in the middle of a second
    repeat (37) @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    expect_v(0); check_next("rst2_en", dut.alarm_en);
    repeat (99) @(posedge mclk);
    #1 expect_v(0); check_next("rst2_sec99", dut.tod_sec);
    @(posedge mclk);
    #1 expect_v(1); check_next("rst2_sec100", dut.tod_sec);

`ifdef KEY_DEBOUNCE_EN
    @(negedge mclk) key[0] = 1'b1;
    @(negedge mclk) key[0] = 1'b0;
    repeat (8) @(negedge mclk);
    expect_v(0); check_next("db_glitch", dut.tod_hour);
    @(negedge mclk) key[0] = 1'b1;
    repeat (3) @(negedge mclk);
    key[0] = 1'b0;
    repeat (8) @(negedge mclk);
    expect_v(1); check_next("db_press", dut.tod_hour);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
